// File: rtl/bcd_fare_accum.sv
// Taxi meter fare accumulator: a 4-digit BCD fare register fed by km and wait pulses.
// It also holds the 4-digit BCD ripple adder that performs every fare update.

module bcd_adder_4 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        c_in,
  output logic [15:0] sum,
  output logic        c_out
);

  always_comb begin : add_digits
    logic [4:0] digit_sum;
    logic       carry;
    carry = c_in;
    sum   = '0;
    for (int i = 0; i < 4; i++) begin
      digit_sum = {1'b0, a[4*i +: 4]} + {1'b0, b[4*i +: 4]} + {4'b0000, carry};
      // Decimal adjust: skip the six unused codes when a digit passes 9.
      if (digit_sum > 5'd9) begin
        digit_sum = digit_sum + 5'd6;
        carry     = 1'b1;
      end else begin
        carry     = 1'b0;
      end
      sum[4*i +: 4] = digit_sum[3:0];
    end
    c_out = carry;
  end

endmodule

module bcd_fare_accum #(
  parameter int FREE_UNITS = 3
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        start,
  input  logic        stop,
  input  logic        clr,
  input  logic        km_pulse,
  input  logic        wait_pulse,
  input  logic [15:0] base_fare,
  input  logic [15:0] km_rate,
  input  logic [15:0] wait_rate,
  output logic [15:0] fare,
  output logic        fare_ovf,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  localparam logic [3:0] FREE_LIM = 4'(FREE_UNITS);

  state_t      state_q, state_d;
  logic [15:0] fare_q, fare_d;
  logic        ovf_q, ovf_d;
  logic        busy_q, busy_d;
  logic [3:0]  free_cnt_q, free_cnt_d;
  logic        wait_pend_q, wait_pend_d;

  logic        pulse_ok;
  logic        km_charge;
  logic        wait_req;
  logic        do_add;
  logic [15:0] add_operand;
  logic [15:0] add_sum;
  logic        add_carry;

  // Operand selection is kept apart from the register update so the adder
  // sits cleanly between two combinational processes.
  always_comb begin
    pulse_ok    = (state_q == RUN) && !clr && !stop;
    km_charge   = pulse_ok && km_pulse && (free_cnt_q >= FREE_LIM);
    wait_req    = pulse_ok && (wait_pend_q || wait_pulse);
    do_add      = km_charge || wait_req;
    add_operand = 16'h0000;
    if (km_charge) begin
      add_operand = km_rate;
    end else if (wait_req) begin
      add_operand = wait_rate;
    end
  end

  bcd_adder_4 u_adder (
    .a     (fare_q),
    .b     (add_operand),
    .c_in  (1'b0),
    .sum   (add_sum),
    .c_out (add_carry)
  );

  always_comb begin
    state_d     = state_q;
    fare_d      = fare_q;
    ovf_d       = ovf_q;
    free_cnt_d  = free_cnt_q;
    wait_pend_d = wait_pend_q;

    if (clr) begin
      state_d     = IDLE;
      fare_d      = 16'h0000;
      ovf_d       = 1'b0;
      free_cnt_d  = 4'd0;
      wait_pend_d = 1'b0;
    end else if (start && (state_q != RUN)) begin
      state_d     = RUN;
      fare_d      = base_fare;
      ovf_d       = 1'b0;
      free_cnt_d  = 4'd0;
      wait_pend_d = 1'b0;
    end else if (stop && (state_q == RUN)) begin
      state_d     = HALT;
      wait_pend_d = 1'b0;
    end else if (state_q == RUN) begin
      if (km_pulse && (free_cnt_q < FREE_LIM)) begin
        free_cnt_d = free_cnt_q + 4'd1;
      end
      // A wait colliding with a chargeable km, or with a pending wait, is deferred one cycle.
      if (km_charge) begin
        wait_pend_d = wait_pend_q || wait_pulse;
      end else begin
        wait_pend_d = wait_pend_q && wait_pulse;
      end
      if (do_add) begin
        if (add_carry) begin
          fare_d = 16'h9999;
          ovf_d  = 1'b1;
        end else begin
          fare_d = add_sum;
        end
      end
    end

    busy_d = (state_d == RUN);
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q     <= IDLE;
      fare_q      <= 16'h0000;
      ovf_q       <= 1'b0;
      busy_q      <= 1'b0;
      free_cnt_q  <= 4'd0;
      wait_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      fare_q      <= fare_d;
      ovf_q       <= ovf_d;
      busy_q      <= busy_d;
      free_cnt_q  <= free_cnt_d;
      wait_pend_q <= wait_pend_d;
    end
  end

  assign fare     = fare_q;
  assign fare_ovf = ovf_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_bcd_fare_accum.sv
// Directed bench for bcd_fare_accum: a table of one-cycle vectors with hand-computed
// fares, followed by a hand-written mid-trip reset sequence.

module tb_bcd_fare_accum;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        start, stop, clr, km_pulse, wait_pulse;
  logic [15:0] base_fare, km_rate, wait_rate;
  logic [15:0] fare;
  logic        fare_ovf, busy;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        start, stop, clr, km, wt;
    logic [15:0] base, kmr, wr;
    logic [15:0] exp_fare;
    logic        exp_ovf, exp_busy;
  } vec_t;

  vec_t vecs[$];

  bcd_fare_accum #(.FREE_UNITS(3)) dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .start      (start),
    .stop       (stop),
    .clr        (clr),
    .km_pulse   (km_pulse),
    .wait_pulse (wait_pulse),
    .base_fare  (base_fare),
    .km_rate    (km_rate),
    .wait_rate  (wait_rate),
    .fare       (fare),
    .fare_ovf   (fare_ovf),
    .busy       (busy)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic add_vec(input logic st, sp, cl, km, wt,
                         input logic [15:0] base, kmr, wr, ef,
                         input logic eo, eb);
    vec_t v;
    v.start = st; v.stop = sp; v.clr = cl; v.km = km; v.wt = wt;
    v.base = base; v.kmr = kmr; v.wr = wr;
    v.exp_fare = ef; v.exp_ovf = eo; v.exp_busy = eb;
    vecs.push_back(v);
  endtask

  // Drive one cycle of inputs, then sample just after the edge that consumed them.
  task automatic apply_stimulus(input logic st, sp, cl, km, wt,
                                input logic [15:0] base, kmr, wr);
    start = st; stop = sp; clr = cl; km_pulse = km; wait_pulse = wt;
    base_fare = base; km_rate = kmr; wait_rate = wr;
    @(posedge sys_clk);
    #1;
  endtask

  task automatic check_output(input string name, input logic [15:0] ef,
                              input logic eo, input logic eb);
    checks++;
    if (fare !== ef) begin
      errors++;
      $display("[TB] FAIL %s fare: got %h expected %h", name, fare, ef);
    end
    checks++;
    if (fare_ovf !== eo) begin
      errors++;
      $display("[TB] FAIL %s fare_ovf: got %b expected %b", name, fare_ovf, eo);
    end
    checks++;
    if (busy !== eb) begin
      errors++;
      $display("[TB] FAIL %s busy: got %b expected %b", name, busy, eb);
    end
  endtask

  initial begin
    // st sp cl km wt  base     kmr      wr       fare     ovf  busy
    add_vec(1,0,0,0,0, 16'h0800, 16'h0150, 16'h0025, 16'h0800, 0, 1);
    add_vec(0,0,0,1,0, 16'h0000, 16'h0150, 16'h0025, 16'h0800, 0, 1);
    add_vec(0,0,0,0,0, 16'h0000, 16'h0150, 16'h0025, 16'h0800, 0, 1);
    add_vec(0,0,0,1,0, 16'h0000, 16'h0150, 16'h0025, 16'h0800, 0, 1);
    add_vec(0,0,0,0,0, 16'h0000, 16'h0150, 16'h0025, 16'h0800, 0, 1);
    add_vec(0,0,0,1,0, 16'h0000, 16'h0150, 16'h0025, 16'h0800, 0, 1);
    add_vec(0,0,0,0,0, 16'h0000, 16'h0150, 16'h0025, 16'h0800, 0, 1);
    add_vec(0,0,0,1,0, 16'h0000, 16'h0150, 16'h0025, 16'h0950, 0, 1);
    add_vec(0,0,0,0,0, 16'h0000, 16'h0150, 16'h0025, 16'h0950, 0, 1);
    add_vec(0,0,0,1,0, 16'h0000, 16'h0150, 16'h0025, 16'h1100, 0, 1);
    add_vec(0,0,0,0,0, 16'h0000, 16'h0150, 16'h0025, 16'h1100, 0, 1);
    add_vec(0,0,0,1,1, 16'h0000, 16'h0150, 16'h0025, 16'h1250, 0, 1);
    add_vec(0,0,0,0,0, 16'h0000, 16'h0150, 16'h0025, 16'h1275, 0, 1);
    add_vec(0,1,0,0,0, 16'h0000, 16'h0150, 16'h0025, 16'h1275, 0, 0);
    add_vec(0,0,0,1,1, 16'h0000, 16'h0150, 16'h0025, 16'h1275, 0, 0);
    add_vec(1,0,0,0,0, 16'h0800, 16'h0150, 16'h0025, 16'h0800, 0, 1);
    add_vec(1,0,0,0,0, 16'h1234, 16'h0150, 16'h0025, 16'h0800, 0, 1);
    add_vec(0,0,1,0,0, 16'h0000, 16'h0150, 16'h0025, 16'h0000, 0, 0);
    add_vec(0,0,0,1,1, 16'h0000, 16'h0150, 16'h0025, 16'h0000, 0, 0);
    add_vec(0,1,0,0,0, 16'h0000, 16'h0150, 16'h0025, 16'h0000, 0, 0);
    add_vec(1,1,0,0,0, 16'h9990, 16'h0020, 16'h0025, 16'h9990, 0, 1);
    add_vec(0,0,0,1,0, 16'h0000, 16'h0020, 16'h0025, 16'h9990, 0, 1);
    add_vec(0,0,0,0,0, 16'h0000, 16'h0020, 16'h0025, 16'h9990, 0, 1);
    add_vec(0,0,0,1,0, 16'h0000, 16'h0020, 16'h0025, 16'h9990, 0, 1);
    add_vec(0,0,0,0,0, 16'h0000, 16'h0020, 16'h0025, 16'h9990, 0, 1);
    add_vec(0,0,0,1,0, 16'h0000, 16'h0020, 16'h0025, 16'h9990, 0, 1);
    add_vec(0,0,0,0,0, 16'h0000, 16'h0020, 16'h0025, 16'h9990, 0, 1);
    add_vec(0,0,0,1,0, 16'h0000, 16'h0020, 16'h0025, 16'h9999, 1, 1);
    add_vec(0,0,0,0,0, 16'h0000, 16'h0020, 16'h0025, 16'h9999, 1, 1);
    add_vec(0,0,0,0,1, 16'h0000, 16'h0020, 16'h0025, 16'h9999, 1, 1);
    add_vec(0,0,0,0,0, 16'h0000, 16'h0020, 16'h0025, 16'h9999, 1, 1);
    add_vec(0,0,0,0,1, 16'h0000, 16'h0020, 16'h0000, 16'h9999, 1, 1);
    add_vec(1,1,0,0,0, 16'h4321, 16'h0020, 16'h0000, 16'h9999, 1, 0);
    add_vec(1,0,0,0,0, 16'h0999, 16'h0150, 16'h0001, 16'h0999, 0, 1);
    add_vec(0,0,0,0,1, 16'h0000, 16'h0150, 16'h0001, 16'h1000, 0, 1);
    add_vec(0,0,0,0,0, 16'h0000, 16'h0150, 16'h0001, 16'h1000, 0, 1);
    add_vec(0,0,0,0,1, 16'h0000, 16'h0150, 16'h0001, 16'h1001, 0, 1);
    add_vec(1,0,1,0,0, 16'h0700, 16'h0150, 16'h0001, 16'h0000, 0, 0);
    add_vec(1,0,0,0,0, 16'h0500, 16'h0150, 16'h0025, 16'h0500, 0, 1);
    add_vec(0,0,0,1,0, 16'h0000, 16'h0150, 16'h0025, 16'h0500, 0, 1);
    add_vec(0,0,0,0,0, 16'h0000, 16'h0150, 16'h0025, 16'h0500, 0, 1);
    add_vec(0,0,0,1,0, 16'h0000, 16'h0150, 16'h0025, 16'h0500, 0, 1);
    add_vec(0,0,0,0,0, 16'h0000, 16'h0150, 16'h0025, 16'h0500, 0, 1);
    add_vec(0,0,0,1,0, 16'h0000, 16'h0150, 16'h0025, 16'h0500, 0, 1);
    add_vec(0,0,0,0,0, 16'h0000, 16'h0150, 16'h0025, 16'h0500, 0, 1);
    add_vec(0,0,0,1,1, 16'h0000, 16'h0150, 16'h0025, 16'h0650, 0, 1);
    add_vec(0,1,0,0,0, 16'h0000, 16'h0150, 16'h0025, 16'h0650, 0, 0);
    add_vec(0,0,0,0,0, 16'h0000, 16'h0150, 16'h0025, 16'h0650, 0, 0);

    sys_rst = 1'b1;
    start = 0; stop = 0; clr = 0; km_pulse = 0; wait_pulse = 0;
    base_fare = '0; km_rate = '0; wait_rate = '0;
    repeat (2) @(posedge sys_clk);
    #1;
    check_output("reset", 16'h0000, 1'b0, 1'b0);
    sys_rst = 1'b0;

    foreach (vecs[i]) begin
      apply_stimulus(vecs[i].start, vecs[i].stop, vecs[i].clr, vecs[i].km, vecs[i].wt,
                     vecs[i].base, vecs[i].kmr, vecs[i].wr);
      check_output($sformatf("vec%0d", i), vecs[i].exp_fare, vecs[i].exp_ovf, vecs[i].exp_busy);
    end

    // Mid-trip reset while a deferred wait is pending: nothing may survive it.
    apply_stimulus(1,0,0,0,0, 16'h0100, 16'h0150, 16'h0025);
    check_output("rst_seq_start", 16'h0100, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      apply_stimulus(0,0,0,1,0, 16'h0000, 16'h0150, 16'h0025);
      apply_stimulus(0,0,0,0,0, 16'h0000, 16'h0150, 16'h0025);
    end
    check_output("rst_seq_free", 16'h0100, 1'b0, 1'b1);
    apply_stimulus(0,0,0,1,1, 16'h0000, 16'h0150, 16'h0025);
    check_output("rst_seq_km", 16'h0250, 1'b0, 1'b1);
    sys_rst = 1'b1;
    apply_stimulus(0,0,0,0,0, 16'h0000, 16'h0150, 16'h0025);
    check_output("rst_seq_reset", 16'h0000, 1'b0, 1'b0);
    sys_rst = 1'b0;
    apply_stimulus(0,0,0,0,0, 16'h0000, 16'h0150, 16'h0025);
    check_output("rst_seq_no_pend", 16'h0000, 1'b0, 1'b0);
    apply_stimulus(1,0,0,0,0, 16'h0100, 16'h0150, 16'h0025);
    check_output("rst_seq_restart", 16'h0100, 1'b0, 1'b1);
    apply_stimulus(0,0,0,1,0, 16'h0000, 16'h0150, 16'h0025);
    check_output("rst_seq_free_cleared", 16'h0100, 1'b0, 1'b1);
    apply_stimulus(0,0,0,0,0, 16'h0000, 16'h0150, 16'h0025);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
